// File: rtl/seg7_scan_capture_pkg.sv
// Shared constants for the 7-segment readback path: segment patterns
// (bit 0 = a .. bit 6 = g, active-low) and the scan FSM state type.
package seg7_pkg;

  localparam int SEG_W = 7;

  // Index i holds the lit pattern for hex digit i.
  localparam logic [SEG_W-1:0] SEG_PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    CAPTURED = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Valid/ready event port carrying confirmed digit changes.
interface seg7_evt_if;
  logic       valid;
  logic [2:0] digit;
  logic [3:0] value;
  logic       ready;

  modport master (output valid, output digit, output value, input ready);
  modport slave  (input valid, input digit, input value, output ready);
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to hex nibble lookup; hit is low for
// any pattern outside the table (blank included).
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output logic             hit_o,
  output logic [3:0]       nib_o
);

  always_comb begin
    hit_o = 1'b0;
    nib_o = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg_i == SEG_PAT[i]) begin
        hit_o = 1'b1;
        nib_o = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples the multiplexed display bus, captures one pattern per stable
// window and confirms per-digit values after repeated identical captures.
//
// state    | meaning
// IDLE     | no single digit enabled
// SETTLE   | one digit enabled, counting stable cycles
// CAPTURED | window already sampled, waiting for the bus to change
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SETTLE_CYC  = 4,
  parameter int MATCH_COUNT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEG_W-1:0]        seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    bad_pattern,
  output logic                    overflow,
  input  logic                    ovf_clr,
  seg7_evt_if.master              evt
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [2:0]    MC       = 3'(MATCH_COUNT);

  logic [SEG_W-1:0]      seg_s1_q, seg_s2_q, seg_prev_q;
  logic [NUM_DIGITS-1:0] an_s1_q, an_s2_q, an_prev_q;
  scan_state_t           state_q;
  logic [CW-1:0]         cnt_q;
  logic                  cap_q, cap_hit_q, bad_q;
  logic [IW-1:0]         cap_dig_q;
  logic [3:0]            cap_nib_q;
  logic [3:0]            cand_q [NUM_DIGITS];
  logic [2:0]            mcnt_q [NUM_DIGITS];
  logic [3:0]            dig_q  [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] vld_q;
  logic                  evt_v_q, ovf_q;
  logic [2:0]            evt_d_q;
  logic [3:0]            evt_n_q;

  logic                  changed, onehot, dec_hit;
  logic [NUM_DIGITS-1:0] an_low;
  logic [IW-1:0]         sel_idx;
  logic [3:0]            dec_nib;
  logic [2:0]            mcnt_d;
  logic                  confirm, drop;

  seg7_pattern_decode u_dec (.seg_i(seg_s2_q), .hit_o(dec_hit), .nib_o(dec_nib));

  assign changed = (seg_s2_q != seg_prev_q) || (an_s2_q != an_prev_q);
  assign an_low  = ~an_s2_q;
  assign onehot  = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s2_q[i]) sel_idx = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q   <= '0;
      seg_s2_q   <= '0;
      seg_prev_q <= '0;
      an_s1_q    <= '0;
      an_s2_q    <= '0;
      an_prev_q  <= '0;
    end else begin
      seg_s1_q   <= seg_in;
      seg_s2_q   <= seg_s1_q;
      seg_prev_q <= seg_s2_q;
      an_s1_q    <= an_in;
      an_s2_q    <= an_s1_q;
      an_prev_q  <= an_s2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cap_q     <= 1'b0;
      cap_hit_q <= 1'b0;
      cap_dig_q <= '0;
      cap_nib_q <= '0;
      bad_q     <= 1'b0;
    end else begin
      cap_q <= 1'b0;
      bad_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (onehot) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
          end
        end
        SETTLE: begin
          if (changed) begin
            state_q <= onehot ? SETTLE : IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= CAPTURED;
            cap_q     <= 1'b1;
            cap_hit_q <= dec_hit;
            cap_nib_q <= dec_nib;
            cap_dig_q <= sel_idx;
            bad_q     <= ~dec_hit;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        CAPTURED: begin
          if (changed) begin
            state_q <= onehot ? SETTLE : IDLE;
            cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Match count the captured digit will hold after this update.
  always_comb begin
    if (!cap_hit_q)                          mcnt_d = 3'd0;
    else if (cap_nib_q != cand_q[cap_dig_q]) mcnt_d = 3'd1;
    else if (mcnt_q[cap_dig_q] == MC)        mcnt_d = MC;
    else                                     mcnt_d = mcnt_q[cap_dig_q] + 3'd1;
  end

  assign confirm = cap_q && cap_hit_q && (mcnt_d == MC) &&
                   (!vld_q[cap_dig_q] || (cap_nib_q != dig_q[cap_dig_q]));
  assign drop    = confirm && evt_v_q && !evt.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        cand_q[d] <= '0;
        mcnt_q[d] <= '0;
        dig_q[d]  <= '0;
      end
      vld_q <= '0;
    end else if (cap_q) begin
      mcnt_q[cap_dig_q] <= mcnt_d;
      if (cap_hit_q) cand_q[cap_dig_q] <= cap_nib_q;
      if (confirm) begin
        dig_q[cap_dig_q] <= cap_nib_q;
        vld_q[cap_dig_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_v_q <= 1'b0;
      evt_d_q <= '0;
      evt_n_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (confirm && !drop) begin
        evt_v_q <= 1'b1;
        evt_d_q <= 3'(cap_dig_q);
        evt_n_q <= cap_nib_q;
      end else if (evt_v_q && evt.ready) begin
        evt_v_q <= 1'b0;
      end
      ovf_q <= drop || (ovf_q && !ovf_clr);
    end
  end

  always_comb begin
    digits_out = '0;
    for (int d = 0; d < NUM_DIGITS; d++) digits_out[4*d +: 4] = dig_q[d];
  end

  assign digit_valid = vld_q;
  assign bad_pattern = bad_q;
  assign overflow    = ovf_q;
  assign evt.valid   = evt_v_q;
  assign evt.digit   = evt_d_q;
  assign evt.value   = evt_n_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Randomised and directed bench for seg7_scan_capture against a
// sample-history reference model of the capture and confirm rules.
module tb_seg7_scan_capture;

  localparam int ND = 4;
  localparam int SC = 4;
  localparam int MC = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [6:0]      seg_in;
  logic [ND-1:0]   an_in;
  logic [4*ND-1:0] digits_out;
  logic [ND-1:0]   digit_valid;
  logic            bad_pattern, overflow, ovf_clr;

  seg7_evt_if evt_if ();

  seg7_scan_capture #(.NUM_DIGITS(ND), .SETTLE_CYC(SC), .MATCH_COUNT(MC)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
    .digits_out(digits_out), .digit_valid(digit_valid),
    .bad_pattern(bad_pattern), .overflow(overflow), .ovf_clr(ovf_clr),
    .evt(evt_if.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Table written in a..g order as listed for the display; bit 0 is segment a.
  function automatic logic [6:0] ag(input logic [6:0] s);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = s[6-i];
    return r;
  endfunction

  function automatic logic [6:0] pat(input int n);
    case (n)
      0: return ag(7'b0000001);  1: return ag(7'b1001111);
      2: return ag(7'b0010010);  3: return ag(7'b0000110);
      4: return ag(7'b1001100);  5: return ag(7'b0100100);
      6: return ag(7'b0100000);  7: return ag(7'b0001111);
      8: return ag(7'b0000000);  9: return ag(7'b0000100);
      10: return ag(7'b0001000); 11: return ag(7'b1100000);
      12: return ag(7'b0110001); 13: return ag(7'b1000010);
      14: return ag(7'b0110000); default: return ag(7'b0111000);
    endcase
  endfunction

  // ---------------- reference model ----------------
  logic [6:0]    p_seg, v_seg;
  logic [ND-1:0] p_an, v_an;
  int            run;
  bit            m_pend, m_ph, m_bad, m_ev, m_ovf;
  int            m_pd, m_pn, m_ed, m_en;
  int            m_cand [ND];
  int            m_cnt  [ND];
  int            m_dig  [ND];
  bit            m_vld  [ND];

  function automatic int lowcount(input logic [ND-1:0] a);
    int c = 0;
    for (int i = 0; i < ND; i++) if (!a[i]) c++;
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_seg = '0; v_seg = '0; p_an = '0; v_an = '0; run = 1;
      m_pend = 0; m_ph = 0; m_bad = 0; m_ev = 0; m_ovf = 0;
      m_pd = 0; m_pn = 0; m_ed = 0; m_en = 0;
      for (int i = 0; i < ND; i++) begin
        m_cand[i] = 0; m_cnt[i] = 0; m_dig[i] = 0; m_vld[i] = 0;
      end
    end else begin
      bit fire;
      fire = 0;
      if (m_pend) begin
        if (!m_ph) m_cnt[m_pd] = 0;
        else if (m_pn == m_cand[m_pd]) begin
          if (m_cnt[m_pd] < MC) m_cnt[m_pd]++;
        end else begin
          m_cand[m_pd] = m_pn; m_cnt[m_pd] = 1;
        end
        if (m_ph && m_cnt[m_pd] == MC &&
            (!m_vld[m_pd] || m_cand[m_pd] != m_dig[m_pd])) begin
          m_dig[m_pd] = m_cand[m_pd]; m_vld[m_pd] = 1; fire = 1;
        end
      end
      if (ovf_clr) m_ovf = 0;
      if (m_ev && evt_if.ready) m_ev = 0;
      if (fire) begin
        if (m_ev) m_ovf = 1;
        else begin m_ev = 1; m_ed = m_pd; m_en = m_pn; end
      end
      // A capture happens once the synchronised bus has held one
      // single-digit value for exactly SC+1 consecutive samples.
      m_pend = 0; m_bad = 0;
      if (lowcount(v_an) == 1 && run == SC + 1) begin
        m_pend = 1; m_ph = 0; m_pn = 0;
        for (int i = 0; i < ND; i++) if (!v_an[i]) m_pd = i;
        for (int k = 0; k < 16; k++) if (v_seg == pat(k)) begin m_ph = 1; m_pn = k; end
        m_bad = !m_ph;
      end
      if (p_seg == v_seg && p_an == v_an) begin
        if (run < 1000) run++;
      end else run = 1;
      v_seg = p_seg; v_an = p_an;
      p_seg = seg_in; p_an = an_in;
    end
  end

  always @(negedge clk) begin
    logic [4*ND-1:0] ed;
    logic [ND-1:0]   ev;
    for (int i = 0; i < ND; i++) begin
      ed[4*i +: 4] = 4'(m_dig[i]);
      ev[i] = m_vld[i];
    end
    chk("digits_out", 32'(digits_out), 32'(ed));
    chk("digit_valid", 32'(digit_valid), 32'(ev));
    chk("bad_pattern", 32'(bad_pattern), 32'(m_bad));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("evt_valid", 32'(evt_if.valid), 32'(m_ev));
    if (m_ev) begin
      chk("evt_digit", 32'(evt_if.digit), 32'(m_ed));
      chk("evt_value", 32'(evt_if.value), 32'(m_en));
    end
  end

  // Accepted events and bad-pattern pulses, for the directed checks.
  int ev_cnt = 0, bad_cnt = 0;
  int ev_d_q[$], ev_v_q[$];
  always @(negedge clk) begin
    if (rst_n && evt_if.valid && evt_if.ready) begin
      ev_cnt++;
      ev_d_q.push_back(int'(evt_if.digit));
      ev_v_q.push_back(int'(evt_if.value));
    end
    if (bad_pattern) bad_cnt++;
  end

  // ---------------- stimulus ----------------
  bit rnd_hs = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ovf_clr = 1'b0;
      if (rnd_hs) begin
        evt_if.ready = 1'($urandom_range(0, 1));
        ovf_clr = ($urandom_range(0, 7) == 0);
      end
    end
  endtask

  task automatic win(input int d, input logic [6:0] s, input int len, input int gap);
    if (gap > 0) begin
      an_in = '1;
      tick(gap);
    end
    an_in  = ~(ND'(1) << d);
    seg_in = s;
    tick(len);
  endtask

  initial begin
    int e0, b0;
    logic [15:0] d_snap;
    rst_n = 1'b0; seg_in = '1; an_in = '1; ovf_clr = 1'b0; evt_if.ready = 1'b1;
    #1;
    chk("reset digits_out", 32'(digits_out), 32'h0);
    chk("reset evt_valid", 32'(evt_if.valid), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // Digit 0 shows "5" for three windows, then a fourth.
    for (int w = 0; w < 3; w++) win(0, pat(5), 10, 3);
    chk("s1 digit0", 32'(digits_out[3:0]), 32'h5);
    chk("s1 valid", 32'(digit_valid), 32'b0001);
    chk("s1 events", 32'(ev_cnt), 32'd1);
    if (ev_cnt > 0) chk("s1 event", 32'({ev_d_q[0][3:0], ev_v_q[0][3:0]}), 32'h05);
    win(0, pat(5), 10, 3);
    chk("s1 no reconfirm event", 32'(ev_cnt), 32'd1);

    // Four digits "1".."4", three rounds.
    e0 = ev_cnt;
    for (int r = 0; r < 3; r++)
      for (int d = 0; d < 4; d++) win(d, pat(d + 1), 10, 2);
    chk("s2 digits", 32'(digits_out), 32'h4321);
    chk("s2 valid", 32'(digit_valid), 32'b1111);
    chk("s2 events", 32'(ev_cnt - e0), 32'd4);
    for (int k = 0; k < 4; k++)
      if (ev_cnt > e0 + k)
        chk("s2 event order", 32'({ev_d_q[e0+k][3:0], ev_v_q[e0+k][3:0]}),
            32'({4'(k), 4'(k + 1)}));

    // Blank on digit 1 flags a bad pattern and restarts its match count.
    b0 = bad_cnt;
    win(1, ag(7'b1111111), 10, 3);
    win(1, ag(7'b1111111), 10, 3);
    chk("s3 bad pulses", 32'(bad_cnt - b0), 32'd2);
    chk("s3 digit1 held", 32'(digits_out[7:4]), 32'h2);
    win(1, pat(7), 10, 3); win(1, pat(7), 10, 3);
    win(1, ag(7'b1111111), 10, 3);
    win(1, pat(7), 10, 3); win(1, pat(7), 10, 3);
    chk("s3 count restarted", 32'(digits_out[7:4]), 32'h2);
    win(1, pat(7), 10, 3);
    chk("s3 digit1 7", 32'(digits_out[7:4]), 32'h7);
    for (int w = 0; w < 3; w++) win(1, pat(10), 10, 3);
    chk("s3 digit1 A", 32'(digits_out[7:4]), 32'hA);

    // Segments toggling every 2 cycles never settle.
    e0 = ev_cnt; b0 = bad_cnt; d_snap = digits_out;
    an_in = '1; tick(3);
    an_in = ~(ND'(1) << 2);
    for (int t = 0; t < 20; t++) begin
      seg_in = t[0] ? pat(8) : pat(9);
      tick(2);
    end
    chk("s4 no event", 32'(ev_cnt - e0), 32'd0);
    chk("s4 no bad", 32'(bad_cnt - b0), 32'd0);
    chk("s4 digits", 32'(digits_out), 32'(d_snap));
    an_in = '1; tick(4);

    // Held event, second confirm dropped.
    evt_if.ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      win(0, pat(9), 10, 2);
      win(3, pat(12), 10, 2);
    end
    chk("s5 evt_valid", 32'(evt_if.valid), 32'd1);
    chk("s5 evt held", 32'({evt_if.digit, evt_if.value}), 32'({3'd0, 4'h9}));
    chk("s5 overflow", 32'(overflow), 32'd1);
    chk("s5 digit0", 32'(digits_out[3:0]), 32'h9);
    chk("s5 digit3", 32'(digits_out[15:12]), 32'hC);
    ovf_clr = 1'b1;
    @(posedge clk); #1; ovf_clr = 1'b0;
    chk("s5 ovf cleared", 32'(overflow), 32'd0);
    chk("s5 evt still pending", 32'(evt_if.valid), 32'd1);

    // Asynchronous reset with an event pending.
    @(posedge clk); #3; rst_n = 1'b0; #1;
    chk("s6 digits", 32'(digits_out), 32'h0);
    chk("s6 valid", 32'(digit_valid), 32'h0);
    chk("s6 evt_valid", 32'(evt_if.valid), 32'h0);
    chk("s6 overflow", 32'(overflow), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; evt_if.ready = 1'b1;
    tick(1);
    win(0, pat(5), 10, 3); win(0, pat(5), 10, 3);
    chk("s6 needs 3 matches", 32'(digit_valid), 32'h0);
    win(0, pat(5), 10, 3);
    chk("s6 reconfirmed", 32'(digit_valid), 32'b0001);
    chk("s6 digit0", 32'(digits_out[3:0]), 32'h5);

    // Random windows, handshake and overflow clears.
    rnd_hs = 1'b1;
    for (int w = 0; w < 300; w++) begin
      logic [6:0] s;
      int g;
      if ($urandom_range(0, 4) == 0) s = 7'($urandom);
      else s = pat($urandom_range(0, 3) + ($urandom_range(0, 3) == 0 ? 8 : 0));
      g = $urandom_range(0, 3);
      if (g > 0 && $urandom_range(0, 3) == 0) begin
        an_in = ND'($urandom);
        tick(g);
        g = 0;
      end
      win($urandom_range(0, ND - 1), s, $urandom_range(2, 12), g);
    end
    rnd_hs = 1'b0;
    evt_if.ready = 1'b1;
    an_in = '1;
    tick(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
